// File: rtl/cam_pkg.sv
// Shared types and geometry for the camera capture path.
// Holds the capture FSM state encoding and the status counter widths.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int FRAME_LINES = 480;
    localparam int Y_WORDS     = 38400;
    localparam int UV_WORDS    = 4800;

    localparam int LINE_W = 10;
    localparam int WR1_W  = 16;
    localparam int WR2_W  = 13;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers a sync pin and flags its rising/falling transitions.
// Edges appear one cycle after the pin changes; no backpressure.
module cam_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic cur;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= sig;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;
    assign fall = prev & ~cur;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Gates frame-buffer write strobes so only whole, requested frames are written.
// Strobes pass with zero latency in CAPTURE; status and control are registered.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int                CNT_W          = 24,
    parameter int                MAX_LINES      = 480,
    parameter logic [CNT_W-1:0]  TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic              MIPI_PIXEL_CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic              ack,
    input  logic              MIPI_PIXEL_VS,
    input  logic              MIPI_PIXEL_HS,
    input  logic              wren1_in,
    input  logic              wren2_in,
    output logic              wren1,
    output logic              wren2,
    output logic              bank,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic [LINE_W-1:0] line_count,
    output logic [WR1_W-1:0]  wr1_count,
    output logic [WR2_W-1:0]  wr2_count
);

    cap_state_t       state;
    logic [CNT_W-1:0] tcnt;
    logic             vs_rise;
    logic             vs_fall;
    logic             hs_rise;
    logic             hs_fall_unused;
    logic             in_cap;
    logic             overrun_now;
    logic             pass;

    cam_sync_edge u_vs_edge (
        .clk   (MIPI_PIXEL_CLK),
        .rst_n (RESET_N),
        .sig   (MIPI_PIXEL_VS),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    cam_sync_edge u_hs_edge (
        .clk   (MIPI_PIXEL_CLK),
        .rst_n (RESET_N),
        .sig   (MIPI_PIXEL_HS),
        .rise  (hs_rise),
        .fall  (hs_fall_unused)
    );

    // Overrun and abort must cut the strobes in the very cycle they occur.
    assign in_cap      = (state == CAPTURE);
    assign overrun_now = in_cap && hs_rise && (line_count == LINE_W'(MAX_LINES));
    assign pass        = in_cap && !abort && !overrun_now;
    assign wren1       = pass & wren1_in;
    assign wren2       = pass & wren2_in;

    always_ff @(posedge MIPI_PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            tcnt        <= '0;
            bank        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            line_count  <= '0;
            wr1_count   <= '0;
            wr2_count   <= '0;
        end else begin
            // Flag sets later in this block override an ack in the same cycle.
            if (ack) begin
                done        <= 1'b0;
                err_timeout <= 1'b0;
                err_overrun <= 1'b0;
            end

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            done        <= 1'b0;
                            err_timeout <= 1'b0;
                            err_overrun <= 1'b0;
                            tcnt        <= '0;
                            state       <= ARM;
                            busy        <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (vs_fall) begin
                            line_count <= '0;
                            wr1_count  <= '0;
                            wr2_count  <= '0;
                            state      <= CAPTURE;
                        end else if (tcnt == TIMEOUT_CYCLES - 1'b1) begin
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (wren1 && !(&wr1_count)) wr1_count <= wr1_count + 1'b1;
                        if (wren2 && !(&wr2_count)) wr2_count <= wr2_count + 1'b1;
                        if (overrun_now) begin
                            err_overrun <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            if (hs_rise) line_count <= line_count + 1'b1;
                            if (vs_rise) begin
                                done  <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        if (start) begin
                            done        <= 1'b0;
                            err_timeout <= 1'b0;
                            err_overrun <= 1'b0;
                        end
                        if (continuous) bank <= ~bank;
                        if (start || continuous) begin
                            tcnt  <= '0;
                            state <= ARM;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: single shot, mid-frame arm, timeout,
// overrun, continuous ping-pong, abort and asynchronous reset.
module tb_cam_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, continuous, ack;
    logic        vs, hs, wren1_in, wren2_in;
    logic        wren1, wren2, bank, busy, done, err_timeout, err_overrun;
    logic [9:0]  line_count;
    logic [15:0] wr1_count;
    logic [12:0] wr2_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cam_capture_ctrl #(.TIMEOUT_CYCLES(24'd1000)) dut (
        .MIPI_PIXEL_CLK (clk),
        .RESET_N        (rst_n),
        .start          (start),
        .abort          (abort),
        .continuous     (continuous),
        .ack            (ack),
        .MIPI_PIXEL_VS  (vs),
        .MIPI_PIXEL_HS  (hs),
        .wren1_in       (wren1_in),
        .wren2_in       (wren2_in),
        .wren1          (wren1),
        .wren2          (wren2),
        .bank           (bank),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun),
        .line_count     (line_count),
        .wr1_count      (wr1_count),
        .wr2_count      (wr2_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: 10 blanking cycles, n lines (HS period 2), blanking again.
    // Index i counts from the first VS-low cycle; capture covers i=2..L+1,
    // or ends just before the overrunning line edge.
    task automatic frame(input string tag, input int n, input bit cap,
                         input int start_line, input bit w2);
        int  len;
        int  wend;
        int  bad;
        bit  win;
        len  = 4 + 2 * n + 4;
        wend = (n > 480) ? (4 + 2 * 480) : (len + 1);
        bad  = 0;
        for (int i = -10; i < len + 3; i++) begin
            step();
            vs       = (i < 0) || (i >= len);
            hs       = (i >= 4) && (i < 4 + 2 * n) && (((i - 4) % 2) == 0);
            wren1_in = (((i + 40) % 4) == 0);
            wren2_in = w2 && (((i + 30) % 3) == 0);
            start    = (start_line >= 0) && (i == 4 + 2 * start_line);
            #1;
            win = cap && (i >= 2) && (i <= wend);
            if ((wren1 !== (win & wren1_in)) || (wren2 !== (win & wren2_in))) bad++;
        end
        start    = 1'b0;
        wren1_in = 1'b0;
        wren2_in = 1'b0;
        chk({tag, "_wren_window_errors"}, bad, 0);
    endtask

    initial begin
        int  bad;
        bit  exp_bank;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0; ack = 1'b0;
        vs = 1'b1; hs = 1'b0; wren1_in = 1'b0; wren2_in = 1'b0;

        // Reset state, with strobes requested
        repeat (3) step();
        wren1_in = 1'b1;
        wren2_in = 1'b1;
        #1;
        chk("rst_wren1", wren1, 0);
        chk("rst_wren2", wren2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bank", bank, 0);
        chk("rst_line_count", line_count, 0);
        wren1_in = 1'b0;
        wren2_in = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();

        // Single shot
        start = 1'b1;
        step();
        start = 1'b0;
        chk("single_arm_busy", busy, 1);
        frame("single", 480, 1'b1, -1, 1'b0);
        chk("single_done", done, 1);
        chk("single_line_count", line_count, 480);
        chk("single_wr1_count", wr1_count, 242);
        chk("single_wr2_count", wr2_count, 0);
        step();
        chk("single_idle_busy", busy, 0);
        chk("single_bank", bank, 0);
        chk("single_done_sticky", done, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_clears_done", done, 0);

        // Arm in the middle of a frame: that frame is skipped
        frame("midarm_skip", 480, 1'b0, 100, 1'b0);
        chk("midarm_still_armed", busy, 1);
        chk("midarm_no_done", done, 0);
        frame("midarm_next", 480, 1'b1, -1, 1'b0);
        chk("midarm_done", done, 1);
        chk("midarm_line_count", line_count, 480);
        chk("midarm_wr1_count", wr1_count, 242);
        step();

        // Frame-start timeout, VS held in blanking
        wren1_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        bad = 0;
        repeat (999) begin
            step();
            if (wren1 !== 1'b0) bad++;
        end
        chk("tmo_busy_before", busy, 1);
        chk("tmo_err_before", err_timeout, 0);
        step();
        chk("tmo_busy_after", busy, 0);
        chk("tmo_err_after", err_timeout, 1);
        chk("tmo_start_cleared_done", done, 0);
        chk("tmo_wren_errors", bad, 0);
        wren1_in = 1'b0;

        // Line overrun: 481 lines
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovr_start_clears_tmo", err_timeout, 0);
        frame("ovr", 481, 1'b1, -1, 1'b0);
        chk("ovr_err", err_overrun, 1);
        chk("ovr_done", done, 0);
        chk("ovr_busy", busy, 0);
        chk("ovr_wr1_count", wr1_count, 241);

        // Continuous ping-pong, three frames
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cont_start_clears_ovr", err_overrun, 0);
        exp_bank = 1'b0;
        for (int f = 0; f < 3; f++) begin
            chk("cont_bank_before", bank, exp_bank);
            frame("cont", 480, 1'b1, -1, 1'b1);
            chk("cont_done", done, 1);
            chk("cont_wr1_count", wr1_count, 242);
            chk("cont_wr2_count", wr2_count, 323);
            ack = 1'b1;
            step();
            ack = 1'b0;
            exp_bank = ~exp_bank;
            chk("cont_bank_after", bank, exp_bank);
            chk("cont_rearmed", busy, 1);
            chk("cont_ack_done", done, 0);
        end

        // Abort during CAPTURE
        continuous = 1'b0;
        vs = 1'b0;
        step();
        step();
        wren1_in = 1'b1;
        #1;
        chk("abort_pre_pass", wren1, 1);
        abort = 1'b1;
        #1;
        chk("abort_same_cycle_gate", wren1, 0);
        chk("abort_busy_same_cycle", busy, 1);
        step();
        abort = 1'b0;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_gate", wren1, 0);
        chk("abort_bank_kept", bank, 1);
        wren1_in = 1'b0;
        vs = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-capture
        start = 1'b1;
        step();
        start = 1'b0;
        vs = 1'b0;
        step();
        step();
        wren1_in = 1'b1;
        step();
        chk("prerst_wren1", wren1, 1);
        chk("prerst_wr1_count", wr1_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wren1", wren1, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bank", bank, 0);
        chk("arst_wr1_count", wr1_count, 0);
        wren1_in = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences frame capture from the MIPI camera pipeline into the two frame-buffer write ports.
- Sits between the YUV packing/address logic and the frame-buffer RAMs. It gates wren1/wren2 so that only whole frames are written, and only on request.
- Provides single-shot and continuous (ping-pong bank) capture, a frame-start timeout, a line-overrun check, and status for the HPS register bridge.

Parameters:
- MAX_LINES, 480, maximum HS pulses allowed per frame before overrun.
- TIMEOUT_CYCLES, 24'd5_000_000, pixel clocks allowed in ARM before timeout error.
- CNT_W, 24, width of the timeout counter.

Ports:
- MIPI_PIXEL_CLK  in  1  sole clock (pixel clock)
- RESET_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; arm capture
- abort  in  1  one-cycle request; return to IDLE, writes off
- continuous  in  1  level; 1 = re-arm automatically after each frame
- ack  in  1  one-cycle; clears done/err flags
- MIPI_PIXEL_VS  in  1  frame sync, high = vertical blanking
- MIPI_PIXEL_HS  in  1  line sync
- wren1_in  in  1  frame buffer 1 write strobe from packer
- wren2_in  in  1  frame buffer 2 write strobe from packer
- wren1  out  1  gated write strobe to frame buffer 1
- wren2  out  1  gated write strobe to frame buffer 2
- bank  out  1  ping-pong bank select (address MSB for the RAM wrapper)
- busy  out  1  high in ARM or CAPTURE
- done  out  1  sticky; a frame completed
- err_timeout  out  1  sticky; no frame start within TIMEOUT_CYCLES
- err_overrun  out  1  sticky; line count exceeded MAX_LINES
- line_count  out  10  HS rising edges in the last or current frame
- wr1_count  out  16  wren1 strobes passed in the last or current frame
- wr2_count  out  13  wren2 strobes passed in the last or current frame

Behaviour:
- Reset (RESET_N=0, asynchronous): state IDLE; every output 0, all counters 0.
- Edge detection: VS and HS are registered once. vs_fall = prev&~cur, vs_rise = ~prev&cur, hs_rise likewise. Edges are therefore seen 1 cycle after the pin changes.
- States:
  - IDLE: writes off. start -> ARM, timeout counter cleared.
  - ARM: timeout counter increments each cycle.
    - vs_fall -> CAPTURE; clear line_count, wr1_count, wr2_count.
    - counter == TIMEOUT_CYCLES-1 -> err_timeout=1, go to IDLE.
  - CAPTURE: wren1 = wren1_in, wren2 = wren2_in, combinational pass-through (zero latency). Each passed strobe increments its counter; counters saturate at all-ones. hs_rise increments line_count.
    - line_count reaches MAX_LINES and another hs_rise occurs -> err_overrun=1, writes off immediately, go to IDLE; done not set.
    - vs_rise -> DONE.
  - DONE: done=1 for this and all later cycles until ack or start.
    - continuous=1: toggle bank, go to ARM next cycle.
    - continuous=0: go to IDLE; bank unchanged.
- busy = (state==ARM)||(state==CAPTURE).
- Outside CAPTURE, wren1 = wren2 = 0 regardless of the inputs.
- abort has priority over every transition in every state: go to IDLE next cycle, writes gated off in that same cycle combinationally, flags and counters retained.
- start while busy: ignored. start in IDLE/DONE: clears done and err flags, then arms.
- ack and an error set in the same cycle: set wins.
- vs_fall and timeout expiry in the same cycle: vs_fall wins (enter CAPTURE).
- A frame already in progress when armed (VS low at arm) is skipped; capture waits for the next vs_fall, so partial frames are never written.
- Counters are visible live during CAPTURE and hold their final values after it.

Decomposition:
- Shared package cam_pkg holds:
  - the state enum (IDLE, ARM, CAPTURE, DONE)
  - frame geometry constants: FRAME_LINES=480, Y_WORDS, UV_WORDS
  - the counter widths
- One natural sub-module: cam_sync_edge, a register plus rise/fall detector instantiated for VS and HS.
- Everything else lives in the top FSM.

Test Plan:
- Single shot: start; VS high 10 cycles, low, 480 HS pulses with wren1_in every 4th cycle, VS high -> wren1 passed only between vs_fall+1 and vs_rise, done=1, line_count=480, bank stays 0.
- Mid-frame arm: start while VS low and 100 lines already elapsed -> no wren1/wren2 until next vs_fall; then a full 480-line capture.
- Timeout: TIMEOUT_CYCLES=1000, start, VS held high -> err_timeout=1 at cycle 1000 after arm, busy=0, wren never asserted.
- Overrun: frame with 481 HS pulses -> err_overrun=1 on the 481st hs_rise, writes gated from that cycle, done=0.
- Continuous: continuous=1, three frames -> done set each frame, bank toggles 0->1->0->1, re-arm without start.
- Abort/priority: abort during CAPTURE with wren1_in=1 -> wren1=0 in that same cycle, IDLE next cycle; reset asserted mid-capture -> all outputs 0 asynchronously.
